// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - two-master round-robin Wishbone arbiter with stall timeout
//
// Purpose: shares one Wishbone slave port between masters m0 and m1. A master
// holds the bus for as long as it keeps cyc high. Simultaneous requests are
// resolved against the last granted master. At least one idle cycle separates
// tenures. A stall counter forces an error after TIMEOUT unacknowledged strobes.
//
// Ports:
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   mN_adr_i/dat_i/sel_i/we_i     master N request (N = 0, 1)
//   mN_cyc_i, mN_stb_i            master N bus request / transfer strobe
//   mN_dat_o, mN_ack_o, mN_err_o  master N response
//   s_adr_o/dat_o/sel_o/we_o      shared slave request
//   s_cyc_o, s_stb_o              shared slave cycle / strobe
//   s_dat_i, s_ack_i, s_err_i     slave response
//   grant_o                       one-hot owner, 2'b00 when idle
//   timeout_o                     one-cycle pulse on a forced timeout error
module wb_rr_arbiter #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);
  localparam logic       TO_EN    = (TIMEOUT != 0);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state, state_nxt;
  logic       owner, owner_nxt;
  logic       last, last_nxt;
  logic [7:0] stall_cnt, stall_cnt_nxt;

  logic       busy;
  logic       own_cyc;
  logic       own_stb;
  logic       timeout_hit;
  logic       err_any;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;  // so m0 wins the first contention
      stall_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      last      <= last_nxt;
      stall_cnt <= stall_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    last_nxt      = last;
    stall_cnt_nxt = 8'd0;

    busy    = (state == BUSY);
    own_cyc = owner ? m1_cyc_i : m0_cyc_i;
    own_stb = owner ? m1_stb_i : m0_stb_i;

    // Only a live strobe can time out, so the forced error always reaches a
    // master that is actually waiting for a response.
    timeout_hit = busy && TO_EN && (stall_cnt == TO_LIMIT) && own_stb;
    err_any     = s_err_i || timeout_hit;

    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    grant_o   = 2'b00;
    timeout_o = timeout_hit;

    if (busy) begin
      s_adr_o = owner ? m1_adr_i : m0_adr_i;
      s_dat_o = owner ? m1_dat_i : m0_dat_i;
      s_sel_o = owner ? m1_sel_i : m0_sel_i;
      s_we_o  = owner ? m1_we_i  : m0_we_i;
      s_cyc_o = own_cyc;
      // The strobe is withheld on the timeout cycle so the slave never sees a
      // transfer that has already been terminated with an error.
      s_stb_o = own_stb && !timeout_hit;
      grant_o = owner ? 2'b10 : 2'b01;
    end

    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    m0_ack_o = s_ack_i && busy && !owner && m0_stb_i;
    m1_ack_o = s_ack_i && busy &&  owner && m1_stb_i;
    m0_err_o = err_any && busy && !owner && m0_stb_i;
    m1_err_o = err_any && busy &&  owner && m1_stb_i;

    if (busy && s_stb_o && !s_ack_i && !s_err_i) begin
      stall_cnt_nxt = stall_cnt + 8'd1;
    end

    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt = BUSY;
          owner_nxt = !last;
        end else if (m0_cyc_i) begin
          state_nxt = BUSY;
          owner_nxt = 1'b0;
        end else if (m1_cyc_i) begin
          state_nxt = BUSY;
          owner_nxt = 1'b1;
        end
      end
      BUSY: begin
        // Dropping back to IDLE (rather than handing over directly) gives the
        // mandatory idle cycle between tenures.
        if (!own_cyc) begin
          state_nxt = IDLE;
          last_nxt  = owner;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - directed self-checking bench for wb_rr_arbiter
module tb_wb_rr_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   m0_adr, m1_adr, s_adr;
  logic [DW-1:0]   m0_wdat, m1_wdat, m0_rdat, m1_rdat, s_wdat, s_rdat;
  logic [DW/8-1:0] m0_sel, m1_sel, s_sel;
  logic            m0_we, m0_cyc, m0_stb, m0_ack, m0_err;
  logic            m1_we, m1_cyc, m1_stb, m1_ack, m1_err;
  logic            s_we, s_cyc, s_stb, s_ack, s_err;
  logic [1:0]      grant;
  logic            timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.DW(DW), .AW(AW), .TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_we_o(s_we), .s_cyc_o(s_cyc), .s_stb_o(s_stb),
    .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err),
    .grant_o(grant), .timeout_o(timeout)
  );

  task automatic clear_inputs();
    m0_adr = '0; m0_wdat = '0; m0_sel = '0; m0_we = 0; m0_cyc = 0; m0_stb = 0;
    m1_adr = '0; m1_wdat = '0; m1_sel = '0; m1_we = 0; m1_cyc = 0; m1_stb = 0;
    s_rdat = '0; s_ack = 0; s_err = 0;
  endtask

  // Leaves the bench in the drive phase of the first cycle after reset.
  task automatic do_reset();
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    m1_cyc = 1; m1_stb = 1; s_rdat = 32'hA5A5_0001;
    rst = 1;
    next_cycle();
    rst = 0;
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b expected 0", s_cyc); end
    checks++; if (s_stb !== 1'b0 || s_adr !== '0) begin errors++; $display("FAIL reset_s_req: stb %b adr %h expected 0", s_stb, s_adr); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    checks++; if (m0_rdat !== 32'hA5A5_0001 || m1_rdat !== 32'hA5A5_0001) begin errors++; $display("FAIL reset_dat_bcast: got %h/%h expected a5a50001", m0_rdat, m1_rdat); end
    m1_cyc = 0; m1_stb = 0;
  endtask

  task automatic test_single();
    do_reset();
    m0_adr = 32'h100; m0_wdat = 32'hDEAD_BEEF; m0_sel = 4'hF; m0_we = 1; m0_cyc = 1; m0_stb = 1;
    @(negedge clk);
    checks++; if (s_cyc !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL single_latency: s_cyc %b grant %b expected 0/00", s_cyc, grant); end
    next_cycle();
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b expected 01", grant); end
    checks++; if (s_adr !== 32'h100 || s_wdat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_s_req: adr %h dat %h expected 100/deadbeef", s_adr, s_wdat); end
    checks++; if (s_we !== 1'b1 || s_stb !== 1'b1 || s_sel !== 4'hF) begin errors++; $display("FAIL single_s_ctl: we %b stb %b sel %h expected 1/1/f", s_we, s_stb, s_sel); end
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL single_early_ack: got %b expected 0", m0_ack); end
    next_cycle();
    s_ack = 1; s_rdat = 32'h1234_5678;
    @(negedge clk);
    checks++; if (m0_ack !== 1'b1) begin errors++; $display("FAIL single_m0_ack: got %b expected 1", m0_ack); end
    checks++; if (m1_ack !== 1'b0) begin errors++; $display("FAIL single_m1_ack: got %b expected 0", m1_ack); end
    checks++; if (m0_rdat !== 32'h1234_5678) begin errors++; $display("FAIL single_rdat: got %h expected 12345678", m0_rdat); end
    next_cycle();
    s_ack = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
    @(negedge clk);
    checks++; if (m0_ack !== 1'b0 || grant !== 2'b01) begin errors++; $display("FAIL single_release: ack %b grant %b expected 0/01", m0_ack, grant); end
    next_cycle();
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_idle: got %b expected 00", grant); end
  endtask

  task automatic test_contention();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
    next_cycle();
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL contend_first: got %b expected 01", grant); end
    checks++; if (s_adr !== 32'h10) begin errors++; $display("FAIL contend_adr0: got %h expected 10", s_adr); end
    next_cycle();
    m0_cyc = 0; m0_stb = 0;
    @(negedge clk);
    checks++; if (grant !== 2'b01 || s_cyc !== 1'b0) begin errors++; $display("FAIL contend_drop: grant %b s_cyc %b expected 01/0", grant, s_cyc); end
    next_cycle();
    @(negedge clk);
    checks++; if (grant !== 2'b00 || s_cyc !== 1'b0) begin errors++; $display("FAIL contend_gap: grant %b s_cyc %b expected 00/0", grant, s_cyc); end
    next_cycle();
    @(negedge clk);
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL contend_second: got %b expected 10", grant); end
    checks++; if (s_adr !== 32'h200 || s_cyc !== 1'b1) begin errors++; $display("FAIL contend_adr1: adr %h cyc %b expected 200/1", s_adr, s_cyc); end
  endtask

  task automatic test_fairness();
    logic exp_owner;
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    next_cycle();
    exp_owner = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (grant !== (exp_owner ? 2'b10 : 2'b01)) begin errors++; $display("FAIL fair_grant_%0d: got %b expected %b", i, grant, (exp_owner ? 2'b10 : 2'b01)); end
      next_cycle();
      if (exp_owner) begin m1_cyc = 0; m1_stb = 0; end else begin m0_cyc = 0; m0_stb = 0; end
      next_cycle();
      if (exp_owner) begin m1_cyc = 1; m1_stb = 1; end else begin m0_cyc = 1; m0_stb = 1; end
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL fair_gap_%0d: got %b expected 00", i, grant); end
      next_cycle();
      exp_owner = !exp_owner;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    m0_cyc = 1; m0_stb = 1;
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      @(negedge clk);
      checks++; if (timeout !== 1'b0 || m0_err !== 1'b0 || s_stb !== 1'b1) begin errors++; $display("FAIL to_stall_%0d: timeout %b err %b stb %b expected 0/0/1", k, timeout, m0_err, s_stb); end
    end
    next_cycle();
    @(negedge clk);
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected 1", timeout); end
    checks++; if (m0_err !== 1'b1 || m1_err !== 1'b0) begin errors++; $display("FAIL to_err: m0 %b m1 %b expected 1/0", m0_err, m1_err); end
    checks++; if (s_stb !== 1'b0 || grant !== 2'b01) begin errors++; $display("FAIL to_stb: stb %b grant %b expected 0/01", s_stb, grant); end
    next_cycle();
    @(negedge clk);
    checks++; if (timeout !== 1'b0 || m0_err !== 1'b0) begin errors++; $display("FAIL to_single: timeout %b err %b expected 0/0", timeout, m0_err); end
    checks++; if (grant !== 2'b01 || s_stb !== 1'b1) begin errors++; $display("FAIL to_hold: grant %b stb %b expected 01/1", grant, s_stb); end
    next_cycle();
    m0_cyc = 0; m0_stb = 0;
    next_cycle();
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL to_release: got %b expected 00", grant); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_cyc = 1; m1_stb = 1;
    next_cycle();
    @(negedge clk);
    checks++; if (grant !== 2'b10 || s_cyc !== 1'b1) begin errors++; $display("FAIL rmid_own: grant %b s_cyc %b expected 10/1", grant, s_cyc); end
    next_cycle();
    rst = 1;
    next_cycle();
    rst = 0; m0_cyc = 1; m0_stb = 1;
    @(negedge clk);
    checks++; if (grant !== 2'b00 || s_cyc !== 1'b0) begin errors++; $display("FAIL rmid_idle: grant %b s_cyc %b expected 00/0", grant, s_cyc); end
    checks++; if (m1_ack !== 1'b0 || m1_err !== 1'b0) begin errors++; $display("FAIL rmid_resp: ack %b err %b expected 0/0", m1_ack, m1_err); end
    next_cycle();
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rmid_m0_wins: got %b expected 01", grant); end
  endtask

  task automatic test_stray();
    do_reset();
    m0_cyc = 1; m0_stb = 0; m1_stb = 1;
    next_cycle();
    s_ack = 1;
    @(negedge clk);
    checks++; if (grant !== 2'b01 || s_stb !== 1'b0) begin errors++; $display("FAIL stray_own: grant %b stb %b expected 01/0", grant, s_stb); end
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin errors++; $display("FAIL stray_ack: m0 %b m1 %b expected 0/0", m0_ack, m1_ack); end
    next_cycle();
    m0_stb = 1;
    @(negedge clk);
    checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin errors++; $display("FAIL stray_real_ack: m0 %b m1 %b expected 1/0", m0_ack, m1_ack); end
    s_ack = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_timeout();
    test_reset_mid();
    test_stray();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
